load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access stage of the rv32i_sc core. It sits directly downstream of the control decoder and the ALU, consuming `mem_read`, `mem_write` and `func3` from the decoder and the ALU result as the effective address. It drives a simple request/acknowledge data bus and returns a sign- or zero-extended load result to write-back. While a memory instruction is outstanding it stalls the core, and it supports a bus timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in WAIT before the access is aborted; 1..65535.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  **reset, asynchronous, active-high**.
- `mem_read`  in  1  load request from the control decoder.
- `mem_write`  in  1  store request from the control decoder.
- `func3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  effective address (ALU result).
- `store_data`  in  32  rs2 value.
- `load_data`  out  32  extended load result; valid in DONE.
- `stall`  out  1  holds PC and register-file write while the access is outstanding.
- `bus_err`  out  1  one-cycle pulse in DONE after a timeout or misalignment trap.
- `bus_req`  out  1  bus request; registered.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wstrb`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  slave completes the transfer this cycle.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.

## Operation
- FSM states:
  - IDLE: if `mem_read|mem_write`, latch addr, func3, store data and direction, then go to REQ.
  - REQ and WAIT: `bus_req=1`. In REQ, `bus_ack` goes to DONE, otherwise go to WAIT. WAIT stays until `bus_ack` (→DONE) or timeout (→DONE with error).
  - DONE: `stall=0`, `load_data` valid, then return to IDLE.
- `stall = (mem_read|mem_write) & (state != DONE)`. This is combinational, so the memory instruction is held from its first cycle.
- Read and write both high: the access is performed as a read and the write is ignored.
- Store lanes use `addr[1:0]`:
  - SB: wstrb = `4'b0001 << addr[1:0]`, wdata = byte ×4.
  - SH: wstrb = `4'b0011 << {addr[1],1'b0}`, wdata = half ×2.
  - SW: wstrb = `4'b1111`.
- Load: select the byte or half from `bus_rdata` by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend. The value is registered on `bus_ack` and held through DONE.
- Unsupported func3 values (011, 110, 111) are performed as a word access.
- Timeout: a 16-bit counter is cleared on entering REQ and increments each cycle in REQ/WAIT. When it reaches `TIMEOUT_CYCLES` without an ack:
  - drop `bus_req`;
  - `load_data=0`;
  - `bus_err=1` in DONE.
- `bus_ack` is ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE, `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wstrb=0`, `bus_wdata=0`, `load_data=0`, `bus_err=0`, counter 0. `stall` then follows its combinational equation.
- Reset mid-access: `bus_req` drops asynchronously and the transaction is abandoned. A late `bus_ack` after reset release is ignored.
- Minimum latency is 3 cycles: accept (IDLE), REQ with same-cycle ack, DONE. Each extra wait cycle adds one.
- Bus outputs stay stable while `bus_req=1`. `bus_req` deasserts the cycle after ack.
- Back-to-back memory instructions: the second is accepted in the IDLE cycle that follows DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a halfword access with `addr[0]=1`, or a word access with `addr[1:0]!=0`, issues no bus request. The FSM goes IDLE→DONE with `bus_err=1` and `load_data=0`; stores write nothing.
- Undefined: low address bits the size cannot honour are ignored, i.e. treated as 0 for H and 00 for W, and the access proceeds normally.

## Test plan
- **LW with immediate ack:** LW at 0x100, ack in REQ with rdata 0xDEADBEEF → `bus_addr=0x100`, `load_data=0xDEADBEEF` in cycle 3, `stall` high for cycles 1–2 only.
- **LB/LBU lane select:** LB at 0x103, rdata 0x80112233 → `load_data=0xFFFFFF80`. LBU at the same address → `0x00000080`.
- **SB/SH lanes:**
  - SB at 0x202, data 0x000000A5 → `bus_wstrb=4'b0100`, `bus_wdata=0xA5A5A5A5`, `bus_we=1`.
  - SH at 0x202, data 0x1234 → wstrb `4'b1100`, wdata `0x12341234`.
- **Slow slave:** ack after 5 WAIT cycles → `stall` high for 7 cycles, `bus_req` stable throughout, no `bus_err`.
- **Timeout:** `TIMEOUT_CYCLES=8`, no ack → `bus_req` drops after 8 cycles, DONE with `bus_err=1`, `load_data=0`.
- **Reset and misalignment:**
  - `rst` asserted in WAIT → `bus_req=0` immediately; an ack after release causes no DONE.
  - With `LSU_MISALIGN_TRAP_EN`, LW at 0x101 → no `bus_req`, `bus_err=1` in cycle 2.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory access stage: latches a load/store, runs it over a req/ack bus, stalls the core
// until DONE, and returns an extended load result. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  // Bus handshake: bus_req rises the cycle after an access is accepted, and the bus outputs
  // stay stable while it is high. A transfer completes in any cycle where bus_req and bus_ack
  // are both high; bus_req falls the following cycle. bus_ack is ignored when bus_req is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt_q;
  logic [1:0]  off_q;
  logic [2:0]  func3_q;
  logic        rd_q;

  logic        req_in, is_b, is_h, is_w, misalign, trap, is_wr, timeout;
  logic [1:0]  off_in;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in, shifted, load_ext;

  assign req_in = mem_read | mem_write;
  assign is_wr  = mem_write & ~mem_read;
  assign is_b   = (func3[1:0] == 2'b00);
  assign is_h   = (func3[1:0] == 2'b01);
  assign is_w   = ~is_b & ~is_h;

  assign misalign = (is_h & addr[0]) | (is_w & (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misalign;
`else
  assign trap = 1'b0;
`endif

  // Byte offset the access actually honours; bits the size cannot use are dropped.
  always_comb begin
    off_in   = 2'b00;
    wstrb_in = 4'b1111;
    wdata_in = store_data;
    if (is_b) begin
      off_in   = addr[1:0];
      wstrb_in = 4'b0001 << addr[1:0];
      wdata_in = {4{store_data[7:0]}};
    end else if (is_h) begin
      off_in   = {addr[1], 1'b0};
      wstrb_in = 4'b0011 << {addr[1], 1'b0};
      wdata_in = {2{store_data[15:0]}};
    end
  end

  assign shifted = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = bus_rdata;
    case (func3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_in) state_nxt = trap ? S_DONE : S_REQ;
      S_REQ, S_WAIT: begin
        if (bus_ack || timeout) state_nxt = S_DONE;
        else                    state_nxt = S_WAIT;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt_q     <= 16'd0;
      off_q     <= 2'b00;
      func3_q   <= 3'b000;
      rd_q      <= 1'b0;
      load_data <= 32'd0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wstrb <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      state   <= state_nxt;
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_in) begin
            cnt_q   <= 16'd0;
            off_q   <= off_in;
            func3_q <= func3;
            rd_q    <= mem_read;
            if (trap) begin
              bus_err   <= 1'b1;
              load_data <= 32'd0;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= is_wr;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= is_wr ? wstrb_in : 4'd0;
              bus_wdata <= is_wr ? wdata_in : 32'd0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (rd_q) load_data <= load_ext;
          end else if (timeout) begin
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall     = req_in & (state != S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed lane/latency/timeout/reset scenarios plus
// randomized accesses checked against an arithmetic reference model and an expected-load queue.
module tb_load_store_unit;

  logic        clk, rst;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
    .addr(addr), .store_data(store_data), .load_data(load_data), .stall(stall),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete access, begun at the next falling edge; leaves the instruction on the inputs
  // during DONE so a following call lands in the IDLE cycle right after it.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdat, input int wait_n);
    int nbytes, off, stall_cnt;
    bit sgn, trap, is_store;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_load, e_addr, got_load;
    logic [63:0] v;
    logic [69:0] snap;
    case (f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      default:    nbytes = 4;
    endcase
    sgn      = (f3 == 3'd0) || (f3 == 3'd1);
    off      = (nbytes == 4) ? 0 : (int'(a % 4) / nbytes) * nbytes;
    trap     = TRAP_EN && (int'(a % 4) % nbytes != 0);
    is_store = wr && !rd;
    e_addr   = a - (a % 4);
    e_strb   = 4'(((1 << nbytes) - 1) << off);
    e_wdata  = (nbytes == 1) ? sd[7:0] * 32'h01010101 :
               (nbytes == 2) ? sd[15:0] * 32'h00010001 : sd;
    v = (64'(rdat) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 64'd1);
    if (sgn && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
    e_load = trap ? 32'd0 : v[31:0];
    if (rd) exp_q.push_back(e_load);

    @(negedge clk);
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = sd;
    #1;
    n_checks++;
    if ({stall, bus_req} !== 2'b10) $display("FAIL accept_cycle: stall,req=%b want 10", {stall, bus_req});
    else n_pass++;
    stall_cnt = int'(stall);

    if (trap) begin
      @(negedge clk);
      n_checks++;
      if ({bus_req, bus_err, stall} !== 3'b010 || load_data !== 32'd0)
        $display("FAIL trap_done: req,err,stall=%b load=%h want 010 00000000", {bus_req, bus_err, stall}, load_data);
      else n_pass++;
      if (rd) void'(exp_q.pop_front());
      return;
    end

    @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== e_addr || bus_we !== is_store)
      $display("FAIL req_cycle: req=%b addr=%h we=%b want 1 %h %b", bus_req, bus_addr, bus_we, e_addr, is_store);
    else n_pass++;
    if (is_store) begin
      n_checks++;
      if (bus_wstrb !== e_strb || bus_wdata !== e_wdata)
        $display("FAIL store_lanes: wstrb=%b wdata=%h want %b %h", bus_wstrb, bus_wdata, e_strb, e_wdata);
      else n_pass++;
    end
    snap = {bus_we, bus_wstrb, bus_addr, bus_wdata, 1'b1};
    for (int i = 0; i < wait_n; i++) begin
      stall_cnt += int'(stall);
      bus_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if ({bus_we, bus_wstrb, bus_addr, bus_wdata, bus_req} !== snap)
        $display("FAIL wait_stable: bus=%h want %h", {bus_we, bus_wstrb, bus_addr, bus_wdata, bus_req}, snap);
      else n_pass++;
    end
    stall_cnt += int'(stall);
    bus_ack = 1'b1; bus_rdata = rdat;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = $urandom;
    n_checks++;
    if ({stall, bus_req, bus_err} !== 3'b000)
      $display("FAIL done_flags: stall,req,err=%b want 000", {stall, bus_req, bus_err});
    else n_pass++;
    n_checks++;
    if (stall_cnt !== wait_n + 2) $display("FAIL stall_len: got %0d want %0d", stall_cnt, wait_n + 2);
    else n_pass++;
    if (rd) begin
      got_load = exp_q.pop_front();
      n_checks++;
      if (load_data !== got_load) $display("FAIL load_data: got %h want %h", load_data, got_load);
      else n_pass++;
    end
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'd0; addr = 32'd0;
    store_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, load_data, bus_err, stall} !== 104'd0)
      $display("FAIL reset_values: req=%b we=%b addr=%h strb=%b wdata=%h load=%h err=%b stall=%b want all 0",
               bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, load_data, bus_err, stall);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_access(1, 0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0);   // LW immediate ack
    go_idle(1);
    do_access(1, 0, 3'd0, 32'h103, 32'd0, 32'h80112233, 0);   // LB
    do_access(1, 0, 3'd4, 32'h103, 32'd0, 32'h80112233, 1);   // LBU
    go_idle(1);
    do_access(0, 1, 3'd0, 32'h202, 32'h000000A5, 32'd0, 0);   // SB
    do_access(0, 1, 3'd1, 32'h202, 32'h00001234, 32'd0, 2);   // SH
    do_access(1, 1, 3'd5, 32'h206, 32'hFFFFFFFF, 32'h8001F00F, 0); // both high -> LHU
    go_idle(2);
  endtask

  task automatic test_slow_slave();
    do_access(1, 0, 3'd1, 32'h402, 32'd0, 32'h9ABC1357, 5);
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    do_access(1, 0, 3'd2, 32'h10, 32'd0, 32'h11223344, 0);
    do_access(0, 1, 3'd2, 32'h14, 32'hCAFEF00D, 32'd0, 0);
    do_access(1, 0, 3'd0, 32'h15, 32'd0, 32'h0000FF00, 0);
    go_idle(1);
  endtask

  task automatic test_timeout();
    int cnt;
    do_access(1, 0, 3'd2, 32'h500, 32'd0, 32'h5A5A5A5A, 0);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; func3 = 3'd2; addr = 32'h300;
    @(negedge clk);
    cnt = 0;
    while (bus_req === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== 8) $display("FAIL timeout_len: req high %0d cycles want 8", cnt);
    else n_pass++;
    n_checks++;
    if ({bus_err, stall} !== 2'b10 || load_data !== 32'd0)
      $display("FAIL timeout_done: err,stall=%b load=%h want 10 00000000", {bus_err, stall}, load_data);
    else n_pass++;
    go_idle(1);
    n_checks++;
    if (bus_err !== 1'b0) $display("FAIL err_pulse: err=%b want 0", bus_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_access(1, 0, 3'd2, 32'h600, 32'd0, 32'h77777777, 0);
    @(negedge clk);
    mem_read = 1'b1; func3 = 3'd2; addr = 32'h700;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || load_data !== 32'd0)
      $display("FAIL reset_async: req=%b load=%h want 0 00000000", bus_req, load_data);
    else n_pass++;
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({bus_req, bus_err, stall} !== 3'b000 || load_data !== 32'd0)
        $display("FAIL late_ack: req,err,stall=%b load=%h want 000 00000000", {bus_req, bus_err, stall}, load_data);
      else n_pass++;
      @(negedge clk);
    end
    do_access(1, 0, 3'd2, 32'h704, 32'd0, 32'h0BADF00D, 1);
    go_idle(1);
  endtask

  task automatic test_misalign();
    do_access(1, 0, 3'd2, 32'h101, 32'd0, 32'hCAFEBABE, 0);   // LW misaligned
    do_access(0, 1, 3'd1, 32'h203, 32'h0000BEEF, 32'd0, 0);   // SH misaligned
    do_access(1, 0, 3'd5, 32'h201, 32'd0, 32'h8765FEDC, 1);   // LHU misaligned
    go_idle(1);
  endtask

  task automatic test_random();
    bit rd, wr;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      do_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0) go_idle(int'($urandom_range(1, 2)));
    end
    go_idle(1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_slow_slave();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
